ps2_scancode_decoder: RTL and testbench

Consumes the raw byte stream from the PS2_Controller (`received_data` / `received_data_en`) and turns PS/2 scan-code set 2 sequences into single-cycle key events. It strips the E0 (extended), F0 (break) and E1 (pause) prefixes, discards keyboard protocol replies, and keeps a held-state vector for the four arrow keys. It sits between PS2_Controller and game or control logic, which consume the events and `arrow_held`.

---
 rtl/ps2_scancode_decoder.sv | 90 +++++++++
 tb/tb_ps2_scancode_decoder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: turns PS/2 set-2 byte sequences into single-cycle key events with arrow held state
module ps2_scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       key_event_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic [3:0] arrow_held,
  output logic       seq_timeout
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;
  state_t state, state_nx;
  logic [2:0] skip, skip_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic ev, ev_ext, ev_rel, tmo;
  logic [7:0] ev_code;
  logic [3:0] amask, arrow_nx;
  logic is_ign;
  assign is_ign = received_data inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  assign amask = {ev_code == 8'h75, ev_code == 8'h72, ev_code == 8'h6B, ev_code == 8'h74};
  assign arrow_nx = (ev && ev_ext) ? (ev_rel ? arrow_held & ~amask : arrow_held | amask) : arrow_held;
  // next state: a byte always wins over the timeout; prefixes in break states restart as from IDLE
  always_comb begin
    state_nx = state;
    skip_nx = skip;
    tmr_nx = (state == IDLE) ? '0 : tmr + 1'b1;
    ev = 1'b0;
    ev_ext = 1'b0;
    ev_rel = 1'b0;
    ev_code = received_data;
    tmo = 1'b0;
    if (received_data_en) begin
      tmr_nx = '0;
      if (state == PAUSE) begin
        skip_nx = skip - 3'd1;
        if (skip <= 3'd1) begin
          ev = 1'b1;
          ev_code = 8'hE1;
          state_nx = IDLE;
        end
      end else if (is_ign) state_nx = IDLE;
      else if (received_data == 8'hF0) state_nx = (state == EXT) ? EXT_BRK : BRK;
      else if (received_data == 8'hE0) state_nx = EXT;
      else if (received_data == 8'hE1) begin
        state_nx = PAUSE;
        skip_nx = 3'd7;
      end else begin
        ev = 1'b1;
        ev_ext = (state == EXT) || (state == EXT_BRK);
        ev_rel = (state == BRK) || (state == EXT_BRK);
        state_nx = IDLE;
      end
    end else if (state != IDLE && tmr == TW'(TIMEOUT_CYCLES - 1)) begin
      state_nx = IDLE;
      skip_nx = 3'd0;
      tmr_nx = '0;
      tmo = 1'b1;
    end
  end
  // registered state and outputs; event fields hold between events
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      skip <= 3'd0;
      tmr <= '0;
      key_event_valid <= 1'b0;
      key_code <= 8'h00;
      key_extended <= 1'b0;
      key_released <= 1'b0;
      arrow_held <= 4'b0000;
      seq_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      skip <= skip_nx;
      tmr <= tmr_nx;
      key_event_valid <= ev;
      key_code <= ev ? ev_code : key_code;
      key_extended <= ev ? ev_ext : key_extended;
      key_released <= ev ? ev_rel : key_released;
      arrow_held <= arrow_nx;
      seq_timeout <= tmo;
    end
  end
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed self-checking bench for the scan-code decoder
module tb_ps2_scancode_decoder;
  logic CLOCK_50, reset, received_data_en, key_event_valid, key_extended, key_released, seq_timeout;
  logic [7:0] received_data, key_code;
  logic [3:0] arrow_held;
  logic [15:0] obs;
  int checks = 0, errors = 0;
  ps2_scancode_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .received_data(received_data),
    .received_data_en(received_data_en), .key_event_valid(key_event_valid),
    .key_code(key_code), .key_extended(key_extended), .key_released(key_released),
    .arrow_held(arrow_held), .seq_timeout(seq_timeout));
  assign obs = {key_event_valid, key_code, key_extended, key_released, arrow_held, seq_timeout};
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;
  // one clock with the given strobe, ending on the next falling edge
  task automatic drive(input logic en, input logic [7:0] d);
    received_data_en = en;
    received_data = d;
    @(negedge CLOCK_50);
  endtask
  task automatic test_reset;
    reset = 1'b1;
    drive(1'b1, 8'h1C);
    checks++;
    if (obs !== 16'h0000) begin errors++; $display("FAIL reset_outputs got %h exp %h", obs, 16'h0000); end
    reset = 1'b0;
    drive(1'b0, 8'h00);
    checks++;
    if (obs !== 16'h0000) begin errors++; $display("FAIL reset_strobe_dropped got %h exp %h", obs, 16'h0000); end
  endtask
  task automatic test_arrow;
    drive(1'b1, 8'hE0);
    checks++;
    if (obs !== {1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0}) begin errors++; $display("FAIL arrow_prefix got %h", obs); end
    drive(1'b1, 8'h75);
    checks++;
    if (obs !== {1'b1, 8'h75, 1'b1, 1'b0, 4'b1000, 1'b0}) begin errors++; $display("FAIL arrow_make got %h exp %h", obs, {1'b1, 8'h75, 1'b1, 1'b0, 4'b1000, 1'b0}); end
    drive(1'b0, 8'h00);
    checks++;
    if (obs !== {1'b0, 8'h75, 1'b1, 1'b0, 4'b1000, 1'b0}) begin errors++; $display("FAIL arrow_hold got %h", obs); end
    drive(1'b1, 8'hE0);
    drive(1'b1, 8'hF0);
    checks++;
    if (obs !== {1'b0, 8'h75, 1'b1, 1'b0, 4'b1000, 1'b0}) begin errors++; $display("FAIL arrow_mid_break got %h", obs); end
    drive(1'b1, 8'h75);
    checks++;
    if (obs !== {1'b1, 8'h75, 1'b1, 1'b1, 4'b0000, 1'b0}) begin errors++; $display("FAIL arrow_break got %h exp %h", obs, {1'b1, 8'h75, 1'b1, 1'b1, 4'b0000, 1'b0}); end
    drive(1'b0, 8'h00);
  endtask
  task automatic test_back_to_back;
    drive(1'b1, 8'h1C);
    checks++;
    if (obs !== {1'b1, 8'h1C, 1'b0, 1'b0, 4'b0000, 1'b0}) begin errors++; $display("FAIL b2b_make got %h", obs); end
    drive(1'b1, 8'hF0);
    checks++;
    if (obs !== {1'b0, 8'h1C, 1'b0, 1'b0, 4'b0000, 1'b0}) begin errors++; $display("FAIL b2b_pulse_width got %h", obs); end
    drive(1'b1, 8'h1C);
    checks++;
    if (obs !== {1'b1, 8'h1C, 1'b0, 1'b1, 4'b0000, 1'b0}) begin errors++; $display("FAIL b2b_break got %h", obs); end
    drive(1'b0, 8'h00);
    checks++;
    if (obs !== {1'b0, 8'h1C, 1'b0, 1'b1, 4'b0000, 1'b0}) begin errors++; $display("FAIL b2b_end got %h", obs); end
  endtask
  task automatic test_noise;
    logic [7:0] seq [4] = '{8'hFA, 8'hAA, 8'hE0, 8'hFA};
    foreach (seq[i]) begin
      drive(1'b1, seq[i]);
      checks++;
      if (obs !== {1'b0, 8'h1C, 1'b0, 1'b1, 4'b0000, 1'b0}) begin errors++; $display("FAIL noise_byte%0d got %h", i, obs); end
    end
    drive(1'b1, 8'h74);
    checks++;
    if (obs !== {1'b1, 8'h74, 1'b0, 1'b0, 4'b0000, 1'b0}) begin errors++; $display("FAIL noise_keypad got %h", obs); end
  endtask
  task automatic test_pause;
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    foreach (seq[i]) begin
      drive(1'b1, seq[i]);
      checks++;
      if (i < 7 && obs !== {1'b0, 8'h74, 1'b0, 1'b0, 4'b0000, 1'b0}) begin errors++; $display("FAIL pause_mid%0d got %h", i, obs); end
      else if (i == 7 && obs !== {1'b1, 8'hE1, 1'b0, 1'b0, 4'b0000, 1'b0}) begin errors++; $display("FAIL pause_event got %h", obs); end
    end
    drive(1'b0, 8'h00);
    checks++;
    if (obs !== {1'b0, 8'hE1, 1'b0, 1'b0, 4'b0000, 1'b0}) begin errors++; $display("FAIL pause_end got %h", obs); end
  endtask
  task automatic test_timeout;
    int pulses = 0, first = 0;
    drive(1'b1, 8'hE0);
    for (int i = 1; i <= 30; i++) begin
      drive(1'b0, 8'h00);
      if (seq_timeout === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL timeout_pulses got %0d exp 1", pulses); end
    checks++;
    if (first !== 16) begin errors++; $display("FAIL timeout_cycle got %0d exp 16", first); end
    checks++;
    if (obs !== {1'b0, 8'hE1, 1'b0, 1'b0, 4'b0000, 1'b0}) begin errors++; $display("FAIL timeout_no_event got %h", obs); end
    drive(1'b1, 8'h6B);
    checks++;
    if (obs !== {1'b1, 8'h6B, 1'b0, 1'b0, 4'b0000, 1'b0}) begin errors++; $display("FAIL timeout_after got %h", obs); end
  endtask
  task automatic test_strobe_at_timeout;
    drive(1'b1, 8'hE0);
    for (int i = 1; i <= 15; i++) drive(1'b0, 8'h00);
    drive(1'b1, 8'hF0);
    checks++;
    if (seq_timeout !== 1'b0) begin errors++; $display("FAIL edge_timeout got %b exp 0", seq_timeout); end
    drive(1'b1, 8'h74);
    checks++;
    if (obs !== {1'b1, 8'h74, 1'b1, 1'b1, 4'b0000, 1'b0}) begin errors++; $display("FAIL edge_break got %h", obs); end
  endtask
  task automatic test_reset_mid;
    drive(1'b1, 8'hE0);
    drive(1'b1, 8'h74);
    checks++;
    if (obs !== {1'b1, 8'h74, 1'b1, 1'b0, 4'b0001, 1'b0}) begin errors++; $display("FAIL rmid_held got %h", obs); end
    drive(1'b1, 8'hE0);
    reset = 1'b1;
    drive(1'b0, 8'h00);
    checks++;
    if (obs !== 16'h0000) begin errors++; $display("FAIL rmid_reset got %h exp 0000", obs); end
    reset = 1'b0;
    drive(1'b1, 8'hF0);
    drive(1'b1, 8'h74);
    checks++;
    if (obs !== {1'b1, 8'h74, 1'b0, 1'b1, 4'b0000, 1'b0}) begin errors++; $display("FAIL rmid_break got %h", obs); end
  endtask
  initial begin
    reset = 1'b1;
    received_data_en = 1'b0;
    received_data = 8'h00;
    @(negedge CLOCK_50);
    test_reset;
    test_arrow;
    test_back_to_back;
    test_noise;
    test_pause;
    test_timeout;
    test_strobe_at_timeout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
